// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg: shared types and round-robin helper for the FIFO port arbiters
package fifo_arb_pkg;
  typedef enum logic {IDLE, BURST} state_t;
  localparam int MAX_REQ = 16;
  localparam int MAX_BURST_DEF = 4;
  localparam int CNT_W = $clog2(MAX_BURST_DEF + 1);
  function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] req, input logic [3:0] ptr, input int n);
    logic [3:0] s;
    int idx;
    s = '0;
    for (int i = MAX_REQ; i >= 1; i--) begin
      idx = (int'(ptr) + i) % n;
      if (i <= n && req[idx]) s = 4'(idx);
    end
    return s;
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester bundle plus FIFO write side of the arbiter
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 8
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0] req_last;
  logic [NUM_REQ-1:0] req_ack;
  logic wfull;
  logic winc;
  logic [WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0] grant;
  logic busy;
  modport master (output req, req_data, req_last, wfull, input req_ack, winc, wdata, grant, busy);
  modport slave (input req, req_data, req_last, wfull, output req_ack, winc, wdata, grant, busy);
endinterface

// File: rtl/fifo_wr_arbiter_rr_select.sv
// rr_select: combinational round-robin pick starting just above ptr
module rr_select
  import fifo_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] sel
);
  assign valid = |req;
  assign sel = IW'(rr_pick(MAX_REQ'(req), 4'(ptr), N));
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst-locking arbiter for one FIFO write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 8,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input logic clk,
  input logic rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = (MAX_BURST == MAX_BURST_DEF) ? CNT_W : $clog2(MAX_BURST + 1);
  state_t state, state_nx;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0] rr_ptr, sel;
  logic [BW-1:0] beat_cnt;
  logic valid, beat, done;
  // rr_ptr doubles as the owner index while bursting: it is only moved at grant time
  rr_select #(.N(NUM_REQ), .IW(IW)) u_sel (.req(bus.req), .ptr(rr_ptr), .valid(valid), .sel(sel));
  // beat decode and next state; a beat that is both last and the cap ends the burst once
  always_comb begin
    beat = (state == BURST) & bus.req[rr_ptr] & ~bus.wfull;
    done = beat & (bus.req_last[rr_ptr] | (beat_cnt == BW'(MAX_BURST - 1)));
    state_nx = (state == IDLE) ? (valid ? BURST : IDLE) : (done ? IDLE : BURST);
  end
  assign bus.winc = beat;
  assign bus.wdata = bus.req_data[int'(rr_ptr)*WIDTH +: WIDTH];
  assign bus.req_ack = beat ? NUM_REQ'(1) << rr_ptr : '0;
  assign bus.grant = grant;
  assign bus.busy = (state == BURST);
  // state, owner, priority pointer and beat counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      rr_ptr <= IW'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && valid) begin
        grant <= NUM_REQ'(1) << sel;
        rr_ptr <= sel;
        beat_cnt <= '0;
      end else if (done) begin
        grant <= '0;
        beat_cnt <= '0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end
endmodule
